adc_test_pattern_cfg: RTL

- Register-mapped configuration controller for the ADC user-test-pattern generator.
- Accepts byte writes to a small register map modelled on the AD9643 test registers, and holds them in shadow registers.
- On a transfer command it commits the shadow set to the generator's control inputs (`select_mode`, `mode_control`, `user_pattern_1..4`).
- Before committing, it forces `select_mode` to 4'b0000 for `RESTART_CYCLES` cycles, so the generator always restarts its sequence at pattern 1 with the new values.

---
 rtl/adc_test_pattern_cfg.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adc_test_pattern_cfg.sv
// rtl/adc_test_pattern_cfg.sv - shadowed test-pattern register map with quiesced commit
module adc_test_pattern_cfg #(
    parameter int unsigned RESTART_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [7:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [3:0]  select_mode,
    output logic        mode_control,
    output logic [15:0] user_pattern_1,
    output logic [15:0] user_pattern_2,
    output logic [15:0] user_pattern_3,
    output logic [15:0] user_pattern_4,
    output logic        busy
);

    localparam logic [3:0] CNT_LOAD = 4'(RESTART_CYCLES - 1);

    typedef enum logic {IDLE, QUIESCE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        start;
    logic        commit;
    logic        wr_fire;

    logic [3:0]  sh_mode;
    logic        sh_pm;
    logic [7:0]  sh_up [0:7];
    logic [3:0]  act_mode;

    logic [7:0]  wr_off;
    logic [7:0]  rd_off;
    logic [7:0]  rd_mux;

    assign wr_fire = wr_valid & wr_ready;
    assign wr_off  = wr_addr - 8'h19;
    assign rd_off  = rd_addr - 8'h19;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        start     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid && wr_addr == 8'hFF && wr_data[0]) begin
                    start     = 1'b1;
                    state_nxt = QUIESCE;
                end
            end
            QUIESCE: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 4'd0;
        end else if (start) begin
            cnt <= CNT_LOAD;
        end else if (state == QUIESCE && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Shadow registers: only written while idle, never visible to the generator directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_mode <= 4'd0;
            sh_pm   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                sh_up[i] <= 8'd0;
            end
        end else if (wr_fire) begin
            if (wr_addr == 8'h0D) begin
                sh_mode <= wr_data[3:0];
                sh_pm   <= wr_data[7];
            end else if (wr_addr >= 8'h19 && wr_addr <= 8'h20) begin
                sh_up[wr_off[2:0]] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_mode       <= 4'd0;
            mode_control   <= 1'b0;
            user_pattern_1 <= 16'h0000;
            user_pattern_2 <= 16'h0000;
            user_pattern_3 <= 16'h0000;
            user_pattern_4 <= 16'h0000;
        end else if (commit) begin
            act_mode       <= sh_mode;
            mode_control   <= sh_pm;
            user_pattern_1 <= {sh_up[1], sh_up[0]};
            user_pattern_2 <= {sh_up[3], sh_up[2]};
            user_pattern_3 <= {sh_up[5], sh_up[4]};
            user_pattern_4 <= {sh_up[7], sh_up[6]};
        end
    end

    // Holding mode 0 while busy makes the generator restart at pattern 1
    assign select_mode = busy ? 4'b0000 : act_mode;

    always_comb begin
        rd_mux = 8'h00;
        if (rd_addr == 8'h0D) begin
            rd_mux = {sh_pm, 3'b000, sh_mode};
        end else if (rd_addr >= 8'h19 && rd_addr <= 8'h20) begin
            rd_mux = sh_up[rd_off[2:0]];
        end else if (rd_addr == 8'hFF) begin
            rd_mux = {7'b0000000, busy};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule
